kme_ob_axis_rx: RTL and testbench

KME_OB_AXIS_RX -- requirements
Module: kme_ob_axis_rx

---
 rtl/kme_axis_pkg.sv | 21 ++
 rtl/kme_ob_axis_rx_if.sv | 34 +++
 rtl/cr_global_params.vh | 8 +
 rtl/kme_axis_fifo.sv | 38 +++
 rtl/kme_ob_axis_rx.sv | 100 ++++++++++
 tb/tb_kme_ob_axis_rx.sv | 276 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/kme_axis_pkg.sv
// Shared types for the KME outbound AXI-stream receiver: beat record and frame FSM states.
package kme_axis_pkg;
`include "cr_global_params.vh"

  localparam int DATA_W = `AXI_S_DP_DWIDTH;
  localparam int STRB_W = `AXI_S_TSTRB_WIDTH;
  localparam int TID_W  = `AXI_S_TID_WIDTH;
  localparam int USER_W = `AXI_S_USER_WIDTH;

  typedef enum logic {ST_IDLE, ST_FRAME} rx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic [TID_W-1:0]  tid;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);
endpackage

// File: rtl/kme_ob_axis_rx_if.sv
// Upstream beat channel plus buffered downstream beat channel of the KME outbound receiver.
interface kme_ob_axis_rx_if;
  import kme_axis_pkg::*;

  logic              kme_ob_tvalid;
  logic              kme_ob_tready;
  logic [DATA_W-1:0] kme_ob_tdata;
  logic [STRB_W-1:0] kme_ob_tstrb;
  logic [TID_W-1:0]  kme_ob_tid;
  logic [USER_W-1:0] kme_ob_tuser;
  logic              kme_ob_tlast;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_tdata;
  logic [STRB_W-1:0] out_tstrb;
  logic [TID_W-1:0]  out_tid;
  logic [USER_W-1:0] out_tuser;
  logic              out_tlast;

  modport master (
    output kme_ob_tvalid, kme_ob_tdata, kme_ob_tstrb, kme_ob_tid, kme_ob_tuser, kme_ob_tlast,
    input  kme_ob_tready,
    input  out_valid, out_tdata, out_tstrb, out_tid, out_tuser, out_tlast,
    output out_ready
  );

  modport slave (
    input  kme_ob_tvalid, kme_ob_tdata, kme_ob_tstrb, kme_ob_tid, kme_ob_tuser, kme_ob_tlast,
    output kme_ob_tready,
    output out_valid, out_tdata, out_tstrb, out_tid, out_tuser, out_tlast,
    input  out_ready
  );
endinterface

// File: rtl/cr_global_params.vh
// Global AXI-stream field widths shared by the outbound KME receive path.
`ifndef CR_GLOBAL_PARAMS_VH
`define CR_GLOBAL_PARAMS_VH
`define AXI_S_DP_DWIDTH    64
`define AXI_S_TSTRB_WIDTH  8
`define AXI_S_TID_WIDTH    2
`define AXI_S_USER_WIDTH   4
`endif

// File: rtl/kme_axis_fifo.sv
// First-word-fall-through FIFO with registered storage; read data is the entry at the read pointer.
module kme_axis_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/kme_ob_axis_rx.sv
// KME outbound AXI-stream receiver: patterned backpressure, beat FIFO, frame tracking and sticky protocol errors.
module kme_ob_axis_rx
  import kme_axis_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bp_pattern,
  input  logic             err_clr,
  kme_ob_axis_rx_if.slave  axis,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             err_strb,
  output logic             err_tid,
  output logic             err_ovf
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]       bp_ptr;
  logic [CW-1:0]    count;
  beat_t            in_beat, out_beat;
  logic             accept, pop, stall_q;
  logic             set_strb, set_tid, set_ovf, latch_tid;
  logic [TID_W-1:0] frame_tid;
  rx_state_e        state_q, state_d;

  // Ready depends only on registered state, never on tvalid or out_ready.
  assign axis.kme_ob_tready = !rst && (count < CW'(DEPTH)) && !bp_pattern[bp_ptr];
  assign axis.out_valid     = !rst && (count != '0);
  assign accept = axis.kme_ob_tvalid && axis.kme_ob_tready;
  assign pop    = axis.out_valid && axis.out_ready;

  assign in_beat = {axis.kme_ob_tdata, axis.kme_ob_tstrb, axis.kme_ob_tid,
                    axis.kme_ob_tuser, axis.kme_ob_tlast};

  kme_axis_fifo #(.DEPTH(DEPTH), .W(BEAT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (in_beat),
    .rdata (out_beat),
    .count (count)
  );

  assign axis.out_tdata = out_beat.data;
  assign axis.out_tstrb = out_beat.strb;
  assign axis.out_tid   = out_beat.tid;
  assign axis.out_tuser = out_beat.user;
  assign axis.out_tlast = out_beat.last;

  always_comb begin
    state_d   = state_q;
    latch_tid = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE:  if (!axis.kme_ob_tlast) begin
                    state_d   = ST_FRAME;
                    latch_tid = 1'b1;
                  end
        ST_FRAME: if (axis.kme_ob_tlast) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // A tlast beat may carry a partial strobe; an empty strobe is never legal.
  assign set_strb = accept && ((!axis.kme_ob_tlast && (axis.kme_ob_tstrb != '1)) ||
                               (axis.kme_ob_tstrb == '0));
  assign set_tid  = accept && (state_q == ST_FRAME) && (axis.kme_ob_tid != frame_tid);
  assign set_ovf  = stall_q && !axis.kme_ob_tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_tid <= '0;
      bp_ptr    <= '0;
      stall_q   <= 1'b0;
      frame_cnt <= '0;
      beat_cnt  <= '0;
      err_strb  <= 1'b0;
      err_tid   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      bp_ptr  <= bp_ptr + 3'd1;
      stall_q <= axis.kme_ob_tvalid && !axis.kme_ob_tready;
      if (latch_tid) frame_tid <= axis.kme_ob_tid;
      if (accept) begin
        beat_cnt <= axis.kme_ob_tlast ? '0 : beat_cnt + 1'b1;
        if (axis.kme_ob_tlast) frame_cnt <= frame_cnt + 1'b1;
      end
      err_strb <= set_strb || (err_strb && !err_clr);
      err_tid  <= set_tid  || (err_tid  && !err_clr);
      err_ovf  <= set_ovf  || (err_ovf  && !err_clr);
    end
  end
endmodule

// File: tb/tb_kme_ob_axis_rx.sv
// Self-checking bench for kme_ob_axis_rx: vector table, corner-case sequences, beat scoreboard.
module tb_kme_ob_axis_rx;
  import kme_axis_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bp_pattern = 8'h00;
  logic        err_clr = 1'b0;
  logic [31:0] frame_cnt, beat_cnt;
  logic        err_strb, err_tid, err_ovf;

  kme_ob_axis_rx_if axis();

  kme_ob_axis_rx #(.DEPTH(8), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bp_pattern (bp_pattern),
    .err_clr    (err_clr),
    .axis       (axis),
    .frame_cnt  (frame_cnt),
    .beat_cnt   (beat_cnt),
    .err_strb   (err_strb),
    .err_tid    (err_tid),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];
  beat_t mon_b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beats are captured from the stimulus at the handshake and matched in order on pop.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (axis.out_valid && axis.out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          mon_b = sb.pop_front();
          chk("sb_beat", {axis.out_tdata, axis.out_tstrb, axis.out_tid, axis.out_tuser, axis.out_tlast}, mon_b);
        end
      end
      if (axis.kme_ob_tvalid && axis.kme_ob_tready)
        sb.push_back({axis.kme_ob_tdata, axis.kme_ob_tstrb, axis.kme_ob_tid, axis.kme_ob_tuser, axis.kme_ob_tlast});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                      input logic [TID_W-1:0] id, input logic l, input bit hold);
    bit ok;
    axis.kme_ob_tvalid = 1'b1;
    axis.kme_ob_tdata  = d;
    axis.kme_ob_tstrb  = s;
    axis.kme_ob_tid    = id;
    axis.kme_ob_tuser  = d[USER_W-1:0];
    axis.kme_ob_tlast  = l;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = axis.kme_ob_tready;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!hold) axis.kme_ob_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    axis.out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      done = (sb.size() == 0) && !axis.out_valid;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    logic [TID_W-1:0]  id;
    logic              l;
    int                fc;
    int                bc;
  } vec_t;

  vec_t tbl[6];
  int   acc;
  bit   t_prev, t_cur;

  initial begin
    axis.kme_ob_tvalid = 1'b0;
    axis.kme_ob_tdata  = '0;
    axis.kme_ob_tstrb  = '0;
    axis.kme_ob_tid    = '0;
    axis.kme_ob_tuser  = '0;
    axis.kme_ob_tlast  = 1'b0;
    axis.out_ready     = 1'b1;

    tbl[0] = '{64'h1111, 8'hFF, 2'd0, 1'b0, 0, 1};
    tbl[1] = '{64'h2222, 8'hFF, 2'd0, 1'b0, 0, 2};
    tbl[2] = '{64'h3333, 8'hFF, 2'd0, 1'b1, 1, 0};
    tbl[3] = '{64'h4444, 8'hFF, 2'd1, 1'b1, 2, 0};
    tbl[4] = '{64'h5555, 8'hFF, 2'd2, 1'b0, 2, 1};
    tbl[5] = '{64'h6666, 8'h0F, 2'd2, 1'b1, 3, 0};

    tick(); tick();
    chk("rst_tready", axis.kme_ob_tready, 0);
    chk("rst_out_valid", axis.out_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_errs", {err_strb, err_tid, err_ovf}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].s, tbl[i].id, tbl[i].l, 1'b0);
      chk("tbl_frame_cnt", frame_cnt, tbl[i].fc);
      chk("tbl_beat_cnt", beat_cnt, tbl[i].bc);
      chk("tbl_errs", {err_strb, err_tid, err_ovf}, 0);
    end

    // 3-beat frame with a free-running sink: one cycle of latency.
    drain();
    chk("idle_out_valid", axis.out_valid, 0);
    send(64'h4201, 8'hFF, 2'd0, 1'b0, 1'b1);
    chk("lat_out_valid", axis.out_valid, 1);
    send(64'h4202, 8'hFF, 2'd0, 1'b0, 1'b1);
    send(64'h4203, 8'hFF, 2'd0, 1'b1, 1'b0);
    chk("f3_frame_cnt", frame_cnt, 4);
    chk("f3_beat_cnt", beat_cnt, 0);
    chk("f3_errs", {err_strb, err_tid, err_ovf}, 0);

    // Fill with a stalled sink, then one pop reopens tready.
    drain();
    axis.out_ready = 1'b0;
    acc = 0;
    axis.kme_ob_tvalid = 1'b1;
    axis.kme_ob_tstrb  = 8'hFF;
    axis.kme_ob_tid    = 2'd0;
    for (int c = 0; c < 14; c++) begin
      axis.kme_ob_tdata = 64'h4300 + 64'(acc);
      axis.kme_ob_tuser = 4'(acc);
      axis.kme_ob_tlast = (acc == 8);
      @(negedge clk);
      if (axis.kme_ob_tready) acc++;
      @(posedge clk); #1;
    end
    chk("full_accepts", acc, 8);
    chk("full_tready", axis.kme_ob_tready, 0);
    axis.kme_ob_tdata = 64'h4308;
    axis.kme_ob_tuser = 4'd8;
    axis.kme_ob_tlast = 1'b1;
    axis.out_ready = 1'b1;
    tick();
    axis.out_ready = 1'b0;
    chk("pop_tready", axis.kme_ob_tready, 1);
    tick();
    axis.kme_ob_tvalid = 1'b0;
    chk("full_frame_cnt", frame_cnt, 5);
    drain();
    chk("full_errs", {err_strb, err_tid, err_ovf}, 0);

    // Alternating backpressure pattern.
    bp_pattern = 8'hAA;
    @(negedge clk);
    t_prev = axis.kme_ob_tready;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      t_cur = axis.kme_ob_tready;
      chk("bp_alt", t_cur, !t_prev);
      t_prev = t_cur;
    end
    tick();
    for (int i = 0; i < 10; i++) send(64'h4400 + 64'(i), 8'hFF, 2'd1, (i == 9), 1'b1);
    axis.kme_ob_tvalid = 1'b0;
    chk("bp_frame_cnt", frame_cnt, 6);
    drain();
    chk("bp_errs", {err_strb, err_tid, err_ovf}, 0);
    bp_pattern = 8'h00;

    // Strobe errors: sticky, cleared by err_clr, set beats clear.
    send(64'h4500, 8'h0F, 2'd0, 1'b0, 1'b0);
    chk("strb_set", err_strb, 1);
    tick(); tick();
    chk("strb_hold", err_strb, 1);
    clr_pulse();
    chk("strb_clr", err_strb, 0);
    send(64'h4501, 8'hFF, 2'd0, 1'b1, 1'b0);
    send(64'h4502, 8'h0F, 2'd0, 1'b1, 1'b0);
    chk("strb_last_partial", err_strb, 0);
    send(64'h4503, 8'h00, 2'd0, 1'b1, 1'b0);
    chk("strb_zero", err_strb, 1);
    clr_pulse();
    err_clr = 1'b1;
    send(64'h4504, 8'h00, 2'd0, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("strb_set_wins", err_strb, 1);
    chk("strb_frame_cnt", frame_cnt, 10);
    clr_pulse();

    // tid changes mid-frame.
    send(64'h4600, 8'hFF, 2'd0, 1'b0, 1'b0);
    chk("tid_first", err_tid, 0);
    send(64'h4601, 8'hFF, 2'd1, 1'b0, 1'b0);
    chk("tid_set", err_tid, 1);
    send(64'h4602, 8'hFF, 2'd0, 1'b1, 1'b0);
    send(64'h4603, 8'hFF, 2'd2, 1'b1, 1'b0);
    chk("tid_frame_cnt", frame_cnt, 12);
    chk("tid_hold", err_tid, 1);
    clr_pulse();
    chk("tid_clr", err_tid, 0);

    // Valid withdrawn while stalled.
    bp_pattern = 8'hFF;
    axis.kme_ob_tvalid = 1'b1;
    axis.kme_ob_tdata  = 64'h4700;
    tick(); tick();
    chk("ovf_not_yet", err_ovf, 0);
    axis.kme_ob_tvalid = 1'b0;
    tick();
    chk("ovf_set", err_ovf, 1);
    bp_pattern = 8'h00;
    clr_pulse();
    chk("ovf_clr", err_ovf, 0);

    // Reset mid-frame with beats still buffered.
    drain();
    axis.out_ready = 1'b0;
    send(64'h4800, 8'hFF, 2'd1, 1'b0, 1'b0);
    send(64'h4801, 8'h0F, 2'd1, 1'b0, 1'b0);
    chk("pre_rst_beat_cnt", beat_cnt, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_tready", axis.kme_ob_tready, 0);
    chk("mid_rst_out_valid", axis.out_valid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_beat_cnt", beat_cnt, 0);
    chk("mid_rst_errs", {err_strb, err_tid, err_ovf}, 0);
    tick();
    rst = 1'b0;
    axis.out_ready = 1'b1;
    tick();
    send(64'h4900, 8'hFF, 2'd3, 1'b0, 1'b0);
    chk("post_rst_beat_cnt", beat_cnt, 1);
    chk("post_rst_frame_cnt0", frame_cnt, 0);
    send(64'h4901, 8'hFF, 2'd3, 1'b1, 1'b0);
    chk("post_rst_frame_cnt1", frame_cnt, 1);
    chk("post_rst_errs", {err_strb, err_tid, err_ovf}, 0);
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
